// File: rtl/msrv32_load_unit_seq_if.sv
// ----------------------------------------------------------------------------
// msrv32_load_unit_seq_if
//
// Data-memory read bus between the msrv32 load unit (master) and the memory
// or bus bridge (slave). The member names keep the historical msrv32 / AHB
// names, so the direction suffixes are from the load unit's point of view.
//
// Signals:
//   ms_riscv32_mp_dmaddr_out  master -> slave  beat-aligned byte address
//   ms_riscv32_mp_dmreq_out   master -> slave  read request, held until ready
//   ms_riscv32_mp_dmdata_in   slave -> master  read data, valid with ready
//   ahb_ready_in              slave -> master  beat complete
//   ahb_resp_in               slave -> master  error response (with ready)
// ----------------------------------------------------------------------------
interface msrv32_load_unit_seq_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) ();

    logic [ADDR_W-1:0] ms_riscv32_mp_dmaddr_out;
    logic              ms_riscv32_mp_dmreq_out;
    logic [XLEN-1:0]   ms_riscv32_mp_dmdata_in;
    logic              ahb_ready_in;
    logic              ahb_resp_in;

    modport master (
        output ms_riscv32_mp_dmaddr_out,
        output ms_riscv32_mp_dmreq_out,
        input  ms_riscv32_mp_dmdata_in,
        input  ahb_ready_in,
        input  ahb_resp_in
    );

    modport slave (
        input  ms_riscv32_mp_dmaddr_out,
        input  ms_riscv32_mp_dmreq_out,
        output ms_riscv32_mp_dmdata_in,
        output ahb_ready_in,
        output ahb_resp_in
    );

endinterface

// File: rtl/msrv32_load_unit_seq.sv
// ----------------------------------------------------------------------------
// msrv32_load_unit_seq
//
// Sequential load unit. Accepts one load request in IDLE, reads one or two
// bus beats, extracts the addressed byte/half/word/double from the merged
// data, sign- or zero-extends it and presents it for one cycle with
// lu_valid_out. Bus errors, illegal sizes and (when splitting is disabled)
// misaligned addresses end the load with lu_err_out=1 and a zero result.
//
// Optional feature macro: MISALIGNED_SPLIT_EN
//   defined   - accesses crossing a beat boundary are done as two beats.
//   undefined - any access not naturally aligned traps without a bus access;
//               the second-beat logic is not built.
//
// Parameters:
//   XLEN    data bus / result width (32 or 64)
//   ADDR_W  byte address width
//
// Ports:
//   ms_riscv32_mp_clk_in  clock, rising edge
//   ms_riscv32_mp_rst_in  asynchronous active-low reset
//   load_req_in           start a load (sampled in IDLE only)
//   load_addr_in          byte address
//   load_size_in          00 byte, 01 half, 10 word, 11 double (XLEN=64)
//   load_unsigned_in      1 = zero-extend, 0 = sign-extend
//   load_busy_out         high from the cycle after accept through DONE
//   bus                   data read bus (master side)
//   lu_output_out         extended result, non-zero only with lu_valid_out
//   lu_valid_out          one-cycle result strobe
//   lu_err_out            error flag, coincident with lu_valid_out
// ----------------------------------------------------------------------------
module msrv32_load_unit_seq #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                   ms_riscv32_mp_clk_in,
    input  logic                   ms_riscv32_mp_rst_in,
    input  logic                   load_req_in,
    input  logic [ADDR_W-1:0]      load_addr_in,
    input  logic [1:0]             load_size_in,
    input  logic                   load_unsigned_in,
    output logic                   load_busy_out,
    msrv32_load_unit_seq_if.master bus,
    output logic [XLEN-1:0]        lu_output_out,
    output logic                   lu_valid_out,
    output logic                   lu_err_out
);

    localparam int B     = XLEN / 8;
    localparam int OFF_W = $clog2(B);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;

    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] aligned_addr;

    logic              dmreq;
    logic [ADDR_W-1:0] dmaddr;
    logic [XLEN-1:0]   out_d;
    logic              err_d;

`ifdef MISALIGNED_SPLIT_EN
    logic [XLEN-1:0]   word0_q;
    logic              capture_w0;
`endif

    // Only a double on a 32-bit bus is an illegal size.
    function automatic logic is_illegal(input logic [1:0] size);
        return (XLEN == 32) && (size == 2'b11);
    endfunction

`ifdef MISALIGNED_SPLIT_EN
    // The access spills into the next beat when off + n exceeds the beat size.
    function automatic logic is_split(input logic [OFF_W-1:0] off, input logic [1:0] size);
        return (int'(off) + (1 << size)) > B;
    endfunction
`else
    // Naturally aligned means the offset is a multiple of the access size.
    function automatic logic is_misaligned(input logic [OFF_W-1:0] off, input logic [1:0] size);
        return (int'(off) & ((1 << size) - 1)) != 0;
    endfunction
`endif

    // Shift the merged {word1, word0} down to the addressed byte, keep the
    // low n bytes and fill the rest with the sign bit or zeros.
    function automatic logic [XLEN-1:0] extract(
        input logic [2*XLEN-1:0] merged,
        input logic [OFF_W-1:0]  off,
        input logic [1:0]        size,
        input logic              uns
    );
        logic [XLEN-1:0] raw;
        logic [XLEN-1:0] res;
        logic            ext;
        int              nbits;
        raw   = XLEN'(merged >> {off, 3'b000});
        nbits = 8 << size;
        case (size)
            2'b00:   ext = raw[7];
            2'b01:   ext = raw[15];
            2'b10:   ext = raw[31];
            default: ext = raw[XLEN-1];
        endcase
        ext = ext & ~uns;
        for (int i = 0; i < XLEN; i++) begin
            res[i] = (i < nbits) ? raw[i] : ext;
        end
        return res;
    endfunction

    assign off_q        = addr_q[OFF_W-1:0];
    assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Next-state, bus drive and result computation.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_next = state;
        dmreq      = 1'b0;
        dmaddr     = '0;
        out_d      = '0;
        err_d      = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        capture_w0 = 1'b0;
`endif

        case (state)
            IDLE: begin
                if (load_req_in) begin
`ifdef MISALIGNED_SPLIT_EN
                    if (is_illegal(load_size_in)) begin
`else
                    if (is_illegal(load_size_in) ||
                        is_misaligned(load_addr_in[OFF_W-1:0], load_size_in)) begin
`endif
                        state_next = DONE;
                        err_d      = 1'b1;
                    end else begin
                        state_next = BEAT0;
                    end
                end
            end

            BEAT0: begin
                dmreq  = 1'b1;
                dmaddr = aligned_addr;
                if (bus.ahb_ready_in) begin
                    if (bus.ahb_resp_in) begin
                        state_next = DONE;
                        err_d      = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
                    end else if (is_split(off_q, size_q)) begin
                        state_next = BEAT1;
                        capture_w0 = 1'b1;
`endif
                    end else begin
                        state_next = DONE;
                        out_d      = extract({{XLEN{1'b0}}, bus.ms_riscv32_mp_dmdata_in},
                                             off_q, size_q, uns_q);
                    end
                end
            end

`ifdef MISALIGNED_SPLIT_EN
            BEAT1: begin
                dmreq  = 1'b1;
                dmaddr = aligned_addr + ADDR_W'(B);
                if (bus.ahb_ready_in) begin
                    state_next = DONE;
                    if (bus.ahb_resp_in) begin
                        err_d = 1'b1;
                    end else begin
                        out_d = extract({bus.ms_riscv32_mp_dmdata_in, word0_q},
                                        off_q, size_q, uns_q);
                    end
                end
            end
`endif

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Result registers load only on the edge into DONE (out_d/err_d are zero
    // on every other edge), so the outputs read zero outside the strobe.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state         <= IDLE;
            addr_q        <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            lu_output_out <= '0;
            lu_err_out    <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            word0_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other one.
            state         <= state_next;
            lu_output_out <= out_d;
            lu_err_out    <= err_d;
            if (state == IDLE && load_req_in) begin
                addr_q <= load_addr_in;
                size_q <= load_size_in;
                uns_q  <= load_unsigned_in;
            end
`ifdef MISALIGNED_SPLIT_EN
            if (capture_w0) begin
                word0_q <= bus.ms_riscv32_mp_dmdata_in;
            end
`endif
        end
    end

    // Status and bus outputs decode straight from the state register, so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign lu_valid_out                 = (state == DONE);
    assign load_busy_out                = (state != IDLE);
    assign bus.ms_riscv32_mp_dmreq_out  = dmreq;
    assign bus.ms_riscv32_mp_dmaddr_out = dmaddr;

endmodule
